// File: rtl/jt12_timer_ctrl_if.sv
// CPU write bus into the timer control block: strobe, address and data.
interface jt12_timer_ctrl_if;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;

    modport master (output wr, addr, din);
    modport slave  (input  wr, addr, din);
endinterface

// File: rtl/jt12_timer_ctrl.sv
// Timer mode registers 0x24-0x27, flag-clear strobes, busy flag and the
// CSM key-on/key-off sequencer driven by timer A overflows.
module jt12_timer_ctrl #(
    parameter int KEYON_LEN = 24,
    parameter int BUSY_LEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    jt12_timer_ctrl_if.slave      bus,
    input  logic                  overflow_A,
    output logic [9:0]            value_A,
    output logic [7:0]            value_B,
    output logic                  load_A,
    output logic                  load_B,
    output logic                  enable_irq_A,
    output logic                  enable_irq_B,
    output logic                  clr_flag_A,
    output logic                  clr_flag_B,
    output logic [1:0]            ch3_mode,
    output logic [3:0]            csm_keyon,
    output logic                  csm_active,
    output logic                  busy
);
    typedef enum logic [1:0] {S_IDLE, S_KEYON, S_KEYOFF} state_t;

    logic [9:0] r_value_A;
    logic [7:0] r_value_B;
    logic       r_load_A, r_load_B, r_irq_A, r_irq_B;
    logic       r_clr_A, r_clr_B;
    logic [1:0] r_ch3_mode;
    logic [7:0] r_busy_cnt;
    logic [7:0] r_hold, w_hold_nxt;
    state_t     r_state, w_state_nxt;
    logic       w_trig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value_A  <= '0;
            r_value_B  <= '0;
            r_load_A   <= 1'b0;
            r_load_B   <= 1'b0;
            r_irq_A    <= 1'b0;
            r_irq_B    <= 1'b0;
            r_clr_A    <= 1'b0;
            r_clr_B    <= 1'b0;
            r_ch3_mode <= '0;
        end else begin
            r_clr_A <= 1'b0;
            r_clr_B <= 1'b0;
            if (bus.wr) begin
                case (bus.addr)
                    8'h24: r_value_A[9:2] <= bus.din;
                    8'h25: r_value_A[1:0] <= bus.din[1:0];
                    8'h26: r_value_B      <= bus.din;
                    8'h27: begin
                        r_load_A   <= bus.din[0];
                        r_load_B   <= bus.din[1];
                        r_irq_A    <= bus.din[2];
                        r_irq_B    <= bus.din[3];
                        r_clr_A    <= bus.din[4];
                        r_clr_B    <= bus.din[5];
                        r_ch3_mode <= bus.din[7:6];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Any write, even to an unmapped address, restarts the busy window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_cnt <= '0;
        end else if (bus.wr) begin
            r_busy_cnt <= 8'(BUSY_LEN);
        end else if (clk_en && r_busy_cnt != 8'd0) begin
            r_busy_cnt <= r_busy_cnt - 8'd1;
        end
    end

    // Uses the registered mode bits, so a same-edge 0x27 write sees the old values.
    assign w_trig = clk_en & overflow_A & r_load_A & (r_ch3_mode == 2'b10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        if (r_ch3_mode != 2'b10) begin
            w_state_nxt = S_IDLE;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        w_state_nxt = S_KEYON;
                        w_hold_nxt  = 8'(KEYON_LEN);
                    end
                end
                S_KEYON: begin
                    // A retrigger beats the hold counter expiring on the same tick.
                    if (w_trig) begin
                        w_hold_nxt = 8'(KEYON_LEN);
                    end else if (clk_en) begin
                        if (r_hold <= 8'd1) begin
                            w_hold_nxt  = '0;
                            w_state_nxt = S_KEYOFF;
                        end else begin
                            w_hold_nxt = r_hold - 8'd1;
                        end
                    end
                end
                S_KEYOFF: begin
                    if (w_trig) begin
                        w_state_nxt = S_KEYON;
                        w_hold_nxt  = 8'(KEYON_LEN);
                    end else if (clk_en) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    assign value_A      = r_value_A;
    assign value_B      = r_value_B;
    assign load_A       = r_load_A;
    assign load_B       = r_load_B;
    assign enable_irq_A = r_irq_A;
    assign enable_irq_B = r_irq_B;
    assign clr_flag_A   = r_clr_A;
    assign clr_flag_B   = r_clr_B;
    assign ch3_mode     = r_ch3_mode;
    assign csm_keyon    = {4{r_state == S_KEYON}};
    assign csm_active   = (r_state != S_IDLE);
    assign busy         = (r_busy_cnt != 8'd0);
endmodule
